driver_motores: RTL and testbench
=================================

Name: driver_motores

Overview:
- Consumes the 8-bit speed pattern and 1-based motor number produced by the motor controller.
- Decodes the pattern into a 2-bit speed level per motor and soft-ramps each motor's applied level toward its target.
- Drives four PWM outputs, one per motor.
- Sits between the controller and the motor power stage.

Parameters:
PWM_BITS, 8, width of the shared PWM counter; PWM period = 2^PWM_BITS clk cycles
RAMP_PERIODS, 4, number of complete PWM periods per one-level ramp step (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
velocidade  input  8  speed pattern from the controller
motorSelecionado  input  3  target motor, 1..4 valid
carregar  input  1  load strobe, sampled on the clk rising edge
pwm  output  4  PWM drive; bit k drives motor k+1
emRampa  output  4  bit k high while motor k+1's applied level differs from its target
nivel  output  8  applied level of each motor, 2 bits per motor; bits [2k+1:2k] belong to motor k+1
erro  output  1  one-cycle pulse on a rejected load

Behaviour:
- Reset, asynchronous: every output and every internal register goes to 0 immediately. This covers pwm, emRampa, nivel, erro, the targets, the PWM counter and the ramp counter. It applies mid-ramp and mid-period; there is no partial state.
- Decode:
  - 00000000 -> level 0
  - 00001111 -> level 1
  - 00110011 -> level 2
  - 11000011 -> level 3
  - Any other pattern is invalid.
- Load: on a clk edge with carregar=1, motorSelecionado in 1..4 and a valid pattern, target[motorSelecionado-1] takes the decoded level.
  - Otherwise, with carregar=1, no target changes and erro=1 for exactly the next cycle.
  - Invalid motor numbers are 0 and 5..7.
  - Back-to-back loads are allowed, one per cycle; the last load to a motor wins.
- PWM counter: free-running, PWM_BITS wide, increments every cycle and wraps from all-ones to 0.
- Duty, registered output, P = 2^PWM_BITS:
  - Level 0: pwm=0.
  - Level 1: pwm=1 while counter < P/4.
  - Level 2: pwm=1 while counter < P/2.
  - Level 3: pwm=1 constantly.
- Ramp counter:
  - Increments on each cycle where the PWM counter equals all-ones.
  - On the wrap cycle where it equals RAMP_PERIODS-1, it returns to 0 and a ramp step fires.
- Ramp step: each motor whose applied level is below its target increments by 1; each motor above its target decrements by 1; equal levels hold.
  - All motors step on the same cycle.
  - The new level takes effect from counter=0, so no period is ever truncated.
- Ramp timing: applied level changes only at ramp steps, so a 0->3 transition takes 3 steps (3*RAMP_PERIODS periods). A load never changes the applied level directly.
- Simultaneous load and ramp step on the same edge: the step compares against the pre-load target. The new target governs the next step.
- emRampa[k] = (applied[k] != target[k]), registered, so it updates the cycle after the load or step.
- Retargeting mid-ramp, e.g. target 3 changed to 1 while applied=2: the next step moves toward the new target. There is no overshoot.

Decomposition:
- Shared package:
  - the four pattern constants PADRAO_NIVEL0..3
  - the 2-bit level type
  - the motor count (4)
  - MOTOR_MIN=1 and MOTOR_MAX=4
- Sub-module pwm_canal: one instance per motor. Inputs are the shared counter and the applied level; the output is the registered pwm bit. It holds the duty comparison only.
- Decode, targets, ramp logic and the counters stay in the top module.

Test Plan (bench uses PWM_BITS=4, RAMP_PERIODS=2; period 16 cycles, step every 32 cycles):
- Reset then idle 64 cycles -> pwm=0000, nivel=0, emRampa=0, erro never pulses.
- Load motor 2 with 11000011 -> emRampa=0010 next cycle. nivel[3:2] goes 1, 2, 3 at successive steps 32 cycles apart. pwm[1] shows high 4/16, then 8/16, then constantly high. emRampa clears after level 3.
- Load motorSelecionado=0, then 5, then motor 1 with 10101010 -> erro pulses 1 cycle after each load. Targets and nivel are unchanged.
- Motor 3 ramping at level 2 toward 3; load motor 3 with 00001111 -> next step gives nivel[5:4]=1. No level 3 ever appears. Duty goes 8/16 to 4/16 at a period boundary.
- Load motor 4 with 00110011 on the exact ramp-step edge -> that step leaves motor 4 at 0. The following step gives level 1.
- Assert reset mid-period while pwm[1]=1 -> pwm drops the same cycle, before the clock edge. After release, everything is back at 0 and the counter restarts at 0.

Source files
------------

// File: rtl/driver_motores_pkg.sv
// Shared types and constants for the motor driver: speed patterns, level type, motor numbering.
package driver_motores_pkg;

    localparam int unsigned NUM_MOTORES = 4;
    localparam int unsigned MOTOR_MIN   = 1;
    localparam int unsigned MOTOR_MAX   = 4;

    localparam logic [7:0] PADRAO_NIVEL0 = 8'b0000_0000;
    localparam logic [7:0] PADRAO_NIVEL1 = 8'b0000_1111;
    localparam logic [7:0] PADRAO_NIVEL2 = 8'b0011_0011;
    localparam logic [7:0] PADRAO_NIVEL3 = 8'b1100_0011;

    typedef logic [1:0] nivel_t;

    typedef struct packed {
        logic   valido;
        nivel_t nivel;
    } decodificado_t;

    // Map a controller speed pattern onto a level; anything unknown is flagged invalid.
    function automatic decodificado_t decodifica(input logic [7:0] padrao);
        decodificado_t r;
        r.valido = 1'b1;
        r.nivel  = 2'd0;
        case (padrao)
            PADRAO_NIVEL0: r.nivel = 2'd0;
            PADRAO_NIVEL1: r.nivel = 2'd1;
            PADRAO_NIVEL2: r.nivel = 2'd2;
            PADRAO_NIVEL3: r.nivel = 2'd3;
            default:       r.valido = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/driver_motores_pwm_canal.sv
// One PWM channel: compares the shared period counter against the duty of the applied level.
module pwm_canal
    import driver_motores_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] contador_i,
    input  nivel_t              nivel_i,
    output logic                pwm_o
);

    localparam logic [PWM_BITS-1:0] QUARTO = PWM_BITS'(1) << (PWM_BITS - 2);
    localparam logic [PWM_BITS-1:0] METADE = PWM_BITS'(1) << (PWM_BITS - 1);

    logic pwm_d;
    logic pwm_q;

    // Duty: 0, 1/4, 1/2 or full period depending on level.
    always_comb begin
        pwm_d = 1'b0;
        case (nivel_i)
            2'd0:    pwm_d = 1'b0;
            2'd1:    pwm_d = (contador_i < QUARTO);
            2'd2:    pwm_d = (contador_i < METADE);
            default: pwm_d = 1'b1;
        endcase
    end

    // Registered drive bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_q <= 1'b0;
        else       pwm_q <= pwm_d;
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/driver_motores.sv
// Motor driver: decodes speed loads into per-motor targets, ramps applied levels, drives four PWMs.
module driver_motores
    import driver_motores_pkg::*;
#(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned RAMP_PERIODS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               velocidade,
    input  logic [2:0]               motorSelecionado,
    input  logic                     carregar,
    output logic [NUM_MOTORES-1:0]   pwm,
    output logic [NUM_MOTORES-1:0]   emRampa,
    output logic [2*NUM_MOTORES-1:0] nivel,
    output logic                     erro
);

    localparam int unsigned RAMPA_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [RAMPA_W-1:0] RAMPA_FIM = RAMPA_W'(RAMP_PERIODS - 1);

    logic [PWM_BITS-1:0]             cnt_q,      cnt_d;
    logic [RAMPA_W-1:0]              rampa_q,    rampa_d;
    nivel_t [NUM_MOTORES-1:0]        alvo_q,     alvo_d;
    nivel_t [NUM_MOTORES-1:0]        aplicado_q, aplicado_d;
    logic [NUM_MOTORES-1:0]          em_rampa_q, em_rampa_d;
    logic                            erro_q,     erro_d;

    decodificado_t dec_c;
    logic          motor_ok_c;
    logic          carga_ok_c;
    logic          passo_c;
    logic [1:0]    idx_c;

    // Next-state: counters, load acceptance, ramp step against pre-load targets.
    always_comb begin
        dec_c      = decodifica(velocidade);
        motor_ok_c = (motorSelecionado >= 3'(MOTOR_MIN)) && (motorSelecionado <= 3'(MOTOR_MAX));
        carga_ok_c = carregar && motor_ok_c && dec_c.valido;
        idx_c      = 2'(motorSelecionado - 3'(MOTOR_MIN));
        passo_c    = (cnt_q == '1) && (rampa_q == RAMPA_FIM);

        cnt_d   = cnt_q + PWM_BITS'(1);
        rampa_d = rampa_q;
        if (cnt_q == '1) begin
            rampa_d = (rampa_q == RAMPA_FIM) ? '0 : rampa_q + RAMPA_W'(1);
        end

        alvo_d = alvo_q;
        if (carga_ok_c) begin
            alvo_d[idx_c] = dec_c.nivel;
        end

        aplicado_d = aplicado_q;
        if (passo_c) begin
            for (int unsigned k = 0; k < NUM_MOTORES; k++) begin
                if (aplicado_q[k] < alvo_q[k])      aplicado_d[k] = aplicado_q[k] + 2'd1;
                else if (aplicado_q[k] > alvo_q[k]) aplicado_d[k] = aplicado_q[k] - 2'd1;
            end
        end

        for (int unsigned k = 0; k < NUM_MOTORES; k++) begin
            em_rampa_d[k] = (aplicado_d[k] != alvo_d[k]);
        end

        erro_d = carregar && !carga_ok_c;
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            rampa_q    <= '0;
            alvo_q     <= '0;
            aplicado_q <= '0;
            em_rampa_q <= '0;
            erro_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rampa_q    <= rampa_d;
            alvo_q     <= alvo_d;
            aplicado_q <= aplicado_d;
            em_rampa_q <= em_rampa_d;
            erro_q     <= erro_d;
        end
    end

    // One duty comparator per motor.
    for (genvar g = 0; g < NUM_MOTORES; g++) begin : g_canal
        pwm_canal #(
            .PWM_BITS (PWM_BITS)
        ) u_pwm (
            .clk        (clk),
            .reset      (reset),
            .contador_i (cnt_q),
            .nivel_i    (aplicado_q[g]),
            .pwm_o      (pwm[g])
        );
    end

    assign nivel   = aplicado_q;
    assign emRampa = em_rampa_q;
    assign erro    = erro_q;

endmodule

// File: tb/tb_driver_motores.sv
// Directed bench for driver_motores with a cycle-count based reference model.
module tb_driver_motores;

    localparam int PWM_BITS     = 4;
    localparam int RAMP_PERIODS = 2;
    localparam int PERIODO      = 1 << PWM_BITS;
    localparam int CICLO_RAMPA  = PERIODO * RAMP_PERIODS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] velocidade = 8'h00;
    logic [2:0] motorSelecionado = 3'd0;
    logic       carregar = 1'b0;
    logic [3:0] pwm;
    logic [3:0] emRampa;
    logic [7:0] nivel;
    logic       erro;

    int n_chk  = 0;
    int n_fail = 0;

    driver_motores #(
        .PWM_BITS     (PWM_BITS),
        .RAMP_PERIODS (RAMP_PERIODS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .velocidade       (velocidade),
        .motorSelecionado (motorSelecionado),
        .carregar         (carregar),
        .pwm              (pwm),
        .emRampa          (emRampa),
        .nivel            (nivel),
        .erro             (erro)
    );

    always #5 clk = ~clk;

    // Reference model: levels, targets and expected outputs derived from the edge count since reset.
    int unsigned n;
    int          m_alvo  [4];
    int          m_nivel [4];
    bit [3:0]    m_pwm;
    bit [3:0]    m_rampa;
    bit          m_erro;

    function automatic int decode(input logic [7:0] p);
        case (p)
            8'b0000_0000: return 0;
            8'b0000_1111: return 1;
            8'b0011_0011: return 2;
            8'b1100_0011: return 3;
            default:      return -1;
        endcase
    endfunction

    function automatic bit duty(input int cnt, input int lvl);
        if (lvl == 3) return 1'b1;
        return (cnt * 4 < lvl * PERIODO);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n = 0;
            for (int k = 0; k < 4; k++) begin
                m_alvo[k] = 0;
                m_nivel[k] = 0;
            end
            m_pwm = '0; m_rampa = '0; m_erro = 1'b0;
        end else begin
            int cnt;
            int d;
            cnt = int'(n % PERIODO);
            for (int k = 0; k < 4; k++) m_pwm[k] = duty(cnt, m_nivel[k]);
            if ((n % CICLO_RAMPA) == CICLO_RAMPA - 1) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_nivel[k] < m_alvo[k])      m_nivel[k]++;
                    else if (m_nivel[k] > m_alvo[k]) m_nivel[k]--;
                end
            end
            m_erro = 1'b0;
            if (carregar) begin
                d = decode(velocidade);
                if (motorSelecionado >= 1 && motorSelecionado <= 4 && d >= 0)
                    m_alvo[motorSelecionado - 1] = d;
                else
                    m_erro = 1'b1;
            end
            for (int k = 0; k < 4; k++) m_rampa[k] = (m_nivel[k] != m_alvo[k]);
            n++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t, edge %0d)", nm, act, exp, $time, n);
        end
    endtask

    // Every-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            logic [7:0] m_nivel_bus;
            for (int k = 0; k < 4; k++) m_nivel_bus[2*k +: 2] = 2'(m_nivel[k]);
            chk("model_pwm",     int'(pwm),     int'(m_pwm));
            chk("model_nivel",   int'(nivel),   int'(m_nivel_bus));
            chk("model_emRampa", int'(emRampa), int'(m_rampa));
            chk("model_erro",    int'(erro),    int'(m_erro));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_edges(input int unsigned alvo);
        int guard;
        guard = 0;
        while (n < alvo && guard < 2000) begin
            tick();
            guard++;
        end
        chk("wait_edges", int'(n), int'(alvo));
    endtask

    task automatic carga(input int m, input logic [7:0] p);
        motorSelecionado = 3'(m);
        velocidade = p;
        carregar = 1'b1;
        tick();
        carregar = 1'b0;
    endtask

    task automatic conta_alto(input int b, output int c);
        c = 0;
        repeat (PERIODO) begin
            tick();
            c += int'(pwm[b]);
        end
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Idle after reset.
        wait_edges(64);
        chk("idle_pwm", int'(pwm), 0);
        chk("idle_nivel", int'(nivel), 0);
        chk("idle_emRampa", int'(emRampa), 0);

        // Motor 2 ramps 0 -> 3.
        carga(2, 8'b1100_0011);
        chk("m2_emRampa_after_load", int'(emRampa), 4'b0010);
        chk("m2_nivel_after_load", int'(nivel), 0);
        wait_edges(96);
        chk("m2_level1", int'(nivel), 8'h04);
        conta_alto(1, c);
        chk("m2_duty_4of16", c, 4);
        wait_edges(128);
        chk("m2_level2", int'(nivel), 8'h08);
        conta_alto(1, c);
        chk("m2_duty_8of16", c, 8);
        wait_edges(160);
        chk("m2_level3", int'(nivel), 8'h0C);
        chk("m2_emRampa_clear", int'(emRampa), 0);
        conta_alto(1, c);
        chk("m2_duty_16of16", c, 16);

        // Rejected loads: motor 0, motor 5, bad pattern.
        motorSelecionado = 3'd0; velocidade = 8'b1100_0011; carregar = 1'b1;
        tick();
        chk("erro_motor0", int'(erro), 1);
        motorSelecionado = 3'd5; velocidade = 8'b0000_1111;
        tick();
        chk("erro_motor5", int'(erro), 1);
        motorSelecionado = 3'd1; velocidade = 8'b1010_1010;
        tick();
        chk("erro_pattern", int'(erro), 1);
        carregar = 1'b0;
        tick();
        chk("erro_drops", int'(erro), 0);
        chk("erro_nivel_kept", int'(nivel), 8'h0C);
        chk("erro_emRampa_kept", int'(emRampa), 0);

        // Motor 3 retargeted 3 -> 1 while at level 2.
        wait_edges(184);
        carga(3, 8'b1100_0011);
        wait_edges(224);
        chk("m3_level2", int'(nivel), 8'h2C);
        chk("m3_ramping", int'(emRampa), 4'b0100);
        wait_edges(230);
        carga(3, 8'b0000_1111);
        wait_edges(240);
        conta_alto(2, c);
        chk("m3_duty_8of16", c, 8);
        chk("m3_level1", int'(nivel), 8'h1C);
        chk("m3_emRampa_clear", int'(emRampa), 0);
        conta_alto(2, c);
        chk("m3_duty_4of16", c, 4);

        // Motor 4 loaded on the exact step edge.
        wait_edges(287);
        carga(4, 8'b0011_0011);
        chk("m4_held_at_0", int'(nivel), 8'h1C);
        chk("m4_emRampa", int'(emRampa), 4'b1000);
        wait_edges(320);
        chk("m4_level1", int'(nivel), 8'h5C);
        wait_edges(352);
        chk("m4_level2", int'(nivel), 8'h9C);
        chk("m4_emRampa_clear", int'(emRampa), 0);

        // Asynchronous reset mid-period.
        chk("pre_reset_pwm1", int'(pwm[1]), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_pwm", int'(pwm), 0);
        chk("async_nivel", int'(nivel), 0);
        chk("async_emRampa", int'(emRampa), 0);
        @(negedge clk);
        #1 reset = 1'b0;

        // Counter restart: first step after release lands on edge 31.
        carga(1, 8'b0000_1111);
        chk("rst_emRampa", int'(emRampa), 4'b0001);
        wait_edges(31);
        chk("rst_before_step", int'(nivel), 0);
        wait_edges(32);
        chk("rst_first_step", int'(nivel), 8'h01);
        chk("rst_pwm_after", int'(pwm), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
